// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and the counter-width helper.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) result++;
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/twos_mag.sv
// Conditional two's-complement negate; gives |x| when neg is the sign bit
// and applies a result sign when neg is the sign to apply.
module twos_mag #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         neg,
    output logic [W-1:0] result
);

    assign result = neg ? -value : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers,
// one result bit per cycle on operand magnitudes, signs restored at the end.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = clog2(WIDTH);

    state_t             state, next_state;
    logic [CW-1:0]      cnt;
    logic               accept, commit;
    logic               is_div_r, neg_a_r, neg_b_r, b_zero_r;
    logic [WIDTH-1:0]   a_orig_r, b_mag_r, acc, lo_r;
    logic               in_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed, rem_fixed;

    assign in_signed = ~op[0];

    twos_mag #(.W(WIDTH)) u_mag_a (.value(A), .neg(in_signed & A[WIDTH-1]), .result(a_mag));
    twos_mag #(.W(WIDTH)) u_mag_b (.value(B), .neg(in_signed & B[WIDTH-1]), .result(b_mag));

    twos_mag #(.W(2*WIDTH)) u_fix_prod (.value({acc, lo_r}), .neg(neg_a_r ^ neg_b_r), .result(prod_fixed));
    twos_mag #(.W(WIDTH))   u_fix_quo  (.value(lo_r), .neg(neg_a_r ^ neg_b_r), .result(quo_fixed));
    twos_mag #(.W(WIDTH))   u_fix_rem  (.value(acc),  .neg(neg_a_r),           .result(rem_fixed));

    // acc holds the running high half (multiply) or partial remainder (divide);
    // lo_r holds the multiplier being consumed or the dividend/quotient bits.
    assign mul_sum   = {1'b0, acc} + (lo_r[0] ? {1'b0, b_mag_r} : '0);
    assign div_shift = {acc, lo_r[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, b_mag_r};
    assign div_diff  = div_shift[WIDTH-1:0] - b_mag_r;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    next_state = CALC;
                    accept     = 1'b1;
                end
            end
            CALC: begin
                if (flush)                        next_state = IDLE;
                else if (cnt == CW'(WIDTH - 1))   next_state = FIX;
            end
            FIX: begin
                next_state = IDLE;
                commit     = !flush;
            end
            default: next_state = IDLE;
        endcase
    end

    // Divide-by-zero overrides the natural result so signed DIV still
    // returns the untouched dividend in HI.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            is_div_r <= 1'b0;
            neg_a_r  <= 1'b0;
            neg_b_r  <= 1'b0;
            b_zero_r <= 1'b0;
            a_orig_r <= '0;
            b_mag_r  <= '0;
            acc      <= '0;
            lo_r     <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= commit;
            if (accept) begin
                cnt      <= '0;
                is_div_r <= op[1];
                neg_a_r  <= in_signed & A[WIDTH-1];
                neg_b_r  <= in_signed & B[WIDTH-1];
                b_zero_r <= (B == '0);
                a_orig_r <= A;
                b_mag_r  <= b_mag;
                acc      <= '0;
                lo_r     <= a_mag;
            end else if (state == CALC) begin
                cnt <= cnt + 1'b1;
                if (is_div_r) begin
                    acc  <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                    lo_r <= {lo_r[WIDTH-2:0], div_ge};
                end else begin
                    acc  <= mul_sum[WIDTH:1];
                    lo_r <= {mul_sum[0], lo_r[WIDTH-1:1]};
                end
            end

            if (commit) begin
                div_zero <= is_div_r & b_zero_r;
                if (is_div_r && b_zero_r) begin
                    hi <= a_orig_r;
                    lo <= '1;
                end else if (is_div_r) begin
                    hi <= rem_fixed;
                    lo <= quo_fixed;
                end else begin
                    hi <= prod_fixed[2*WIDTH-1:WIDTH];
                    lo <= prod_fixed[WIDTH-1:0];
                end
            end else if (state == IDLE) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: 32-bit and 8-bit instances, directed
// vectors with hand-computed results, monitors pop expectations on done.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        start32 = 0, flush32 = 0, hi_we32 = 0, lo_we32 = 0;
    logic [1:0]  op32 = 0;
    logic [31:0] a32 = 0, b32 = 0, wdata32 = 0;
    logic        busy32, done32, dz32;
    logic [31:0] hi32, lo32;

    logic        start8 = 0;
    logic [1:0]  op8 = 0;
    logic [7:0]  a8 = 0, b8 = 0;
    logic        busy8, done8, dz8;
    logic [7:0]  hi8, lo8;

    exp_t q32[$];
    exp_t q8[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .op(op32), .A(a32), .B(b32),
        .flush(flush32), .hi_we(hi_we32), .lo_we(lo_we32), .wdata(wdata32),
        .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .A(a8), .B(b8),
        .flush(1'b0), .hi_we(1'b0), .lo_we(1'b0), .wdata(8'h00),
        .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (done32) begin
            exp_t e;
            if (q32.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_done32: got done=1 hi=%h lo=%h, expected no done", hi32, lo32);
            end else begin
                e = q32.pop_front();
                checkOutput("hi32", hi32, e.hi);
                checkOutput("lo32", lo32, e.lo);
                checkOutput("div_zero32", {31'b0, dz32}, {31'b0, e.dz});
            end
        end
    end

    always @(negedge clk) begin
        if (done8) begin
            exp_t e;
            if (q8.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_done8: got done=1, expected no done");
            end else begin
                e = q8.pop_front();
                checkOutput("hi8", {24'b0, hi8}, e.hi);
                checkOutput("lo8", {24'b0, lo8}, e.lo);
                checkOutput("div_zero8", {31'b0, dz8}, {31'b0, e.dz});
            end
        end
    end

    task automatic waitDone32(output int cycles);
        cycles = 0;
        while (busy32 && cycles < 100) begin
            cycles++;
            @(posedge clk); #1;
        end
        if (busy32) begin
            total++;
            bad++;
            $display("[TB] FAIL timeout32: busy=%0b after %0d cycles, expected 0", busy32, cycles);
        end
    endtask

    task automatic applyStimulus32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                   input bit push, input logic [31:0] ehi, input logic [31:0] elo,
                                   input logic edz);
        int   n;
        exp_t e;
        waitDone32(n);
        op32 = o;
        a32 = a;
        b32 = b;
        start32 = 1'b1;
        if (push) begin
            e.hi = ehi;
            e.lo = elo;
            e.dz = edz;
            q32.push_back(e);
        end
        @(posedge clk); #1;
        start32 = 1'b0;
    endtask

    task automatic run32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
        int n;
        applyStimulus32(o, a, b, 1'b1, ehi, elo, edz);
        waitDone32(n);
    endtask

    task automatic run8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ehi, input logic [7:0] elo, input logic edz,
                        output int cycles);
        exp_t e;
        op8 = o;
        a8 = a;
        b8 = b;
        start8 = 1'b1;
        e.hi = {24'b0, ehi};
        e.lo = {24'b0, elo};
        e.dz = edz;
        q8.push_back(e);
        @(posedge clk); #1;
        start8 = 1'b0;
        cycles = 0;
        while (busy8 && cycles < 50) begin
            cycles++;
            @(posedge clk); #1;
        end
        if (busy8) begin
            total++;
            bad++;
            $display("[TB] FAIL timeout8: busy=%0b after %0d cycles, expected 0", busy8, cycles);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;

        #1 reset = 1'b1;
        #11;
        checkOutput("rst_hi", hi32, 32'h0);
        checkOutput("rst_lo", lo32, 32'h0);
        checkOutput("rst_busy", {31'b0, busy32}, 32'h0);
        checkOutput("rst_done", {31'b0, done32}, 32'h0);
        checkOutput("rst_dz", {31'b0, dz32}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // MULT -3 * 5 with latency and done-pulse width
        applyStimulus32(OP_MULT, 32'hFFFFFFFD, 32'd5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        waitDone32(n);
        checkOutput("mult_latency", n, 32'd33);
        checkOutput("done_pulse", {31'b0, done32}, 32'd1);
        @(posedge clk); #1;
        checkOutput("done_one_cycle", {31'b0, done32}, 32'd0);

        // MULTU max*max, then DIV issued in the done cycle
        applyStimulus32(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        waitDone32(n);
        checkOutput("b2b_done", {31'b0, done32}, 32'd1);
        applyStimulus32(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        checkOutput("b2b_busy", {31'b0, busy32}, 32'd1);
        waitDone32(n);

        run32(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        run32(OP_DIV,  32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
        run32(OP_DIV,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0);
        run32(OP_DIVU, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0);
        run32(OP_DIVU, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 1'b1);
        repeat (3) @(posedge clk);
        #1 checkOutput("dz_hold", {31'b0, dz32}, 32'd1);
        run32(OP_DIV,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
        run32(OP_MULTU, 32'd2,       32'd3,        32'h00000000, 32'h00000006, 1'b0);

        // direct HI write in the same edge as start; result overwrites it
        hi_we32 = 1'b1;
        wdata32 = 32'hAAAA5555;
        applyStimulus32(OP_MULTU, 32'd4, 32'd5, 1'b1, 32'h0, 32'd20, 1'b0);
        hi_we32 = 1'b0;
        checkOutput("write_with_start", hi32, 32'hAAAA5555);
        waitDone32(n);

        // start and hi_we while busy are ignored
        applyStimulus32(OP_MULTU, 32'd3, 32'd3, 1'b1, 32'h0, 32'd9, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        hi_we32 = 1'b1;
        wdata32 = 32'hDEADBEEF;
        start32 = 1'b1;
        op32 = OP_MULTU;
        a32 = 32'd7;
        b32 = 32'd7;
        @(posedge clk); #1;
        hi_we32 = 1'b0;
        start32 = 1'b0;
        checkOutput("hi_we_busy_ignored", hi32, 32'h0);
        waitDone32(n);
        repeat (3) @(posedge clk);
        #1 checkOutput("start_busy_ignored", {31'b0, busy32}, 32'd0);

        // flush at CALC cycle 10 keeps HI/LO
        hi_we32 = 1'b1;
        lo_we32 = 1'b1;
        wdata32 = 32'h11112222;
        @(posedge clk); #1;
        hi_we32 = 1'b0;
        lo_we32 = 1'b0;
        applyStimulus32(OP_MULT, 32'd5, 32'd5, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (10) @(posedge clk);
        #1 flush32 = 1'b1;
        @(posedge clk); #1;
        flush32 = 1'b0;
        checkOutput("flush_idle", {31'b0, busy32}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        checkOutput("flush_hi", hi32, 32'h11112222);
        checkOutput("flush_lo", lo32, 32'h11112222);

        // flush in the FIX cycle suppresses the write
        applyStimulus32(OP_MULTU, 32'd6, 32'd7, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (32) @(posedge clk);
        #1 flush32 = 1'b1;
        @(posedge clk); #1;
        flush32 = 1'b0;
        checkOutput("fix_flush_done", {31'b0, done32}, 32'd0);
        checkOutput("fix_flush_lo", lo32, 32'h11112222);

        // flush beats start in IDLE
        flush32 = 1'b1;
        start32 = 1'b1;
        @(posedge clk); #1;
        flush32 = 1'b0;
        start32 = 1'b0;
        checkOutput("flush_beats_start", {31'b0, busy32}, 32'd0);

        // reset mid-CALC clears outputs immediately
        run32(OP_DIVU, 32'd9, 32'd0, 32'h00000009, 32'hFFFFFFFF, 1'b1);
        applyStimulus32(OP_MULTU, 32'd3, 32'd3, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("midrst_hi", hi32, 32'h0);
        checkOutput("midrst_lo", lo32, 32'h0);
        checkOutput("midrst_busy", {31'b0, busy32}, 32'd0);
        checkOutput("midrst_dz", {31'b0, dz32}, 32'd0);
        #2 reset = 1'b0;
        @(posedge clk); #1;

        // 8-bit instance
        run8(OP_MULT, 8'h80, 8'h80, 8'h40, 8'h00, 1'b0, n);
        checkOutput("latency8", n, 32'd9);
        run8(OP_MULTU, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0, n);
        run8(OP_MULT,  8'hFF, 8'hFF, 8'h00, 8'h01, 1'b0, n);
        run8(OP_MULT,  8'h7F, 8'h80, 8'hC0, 8'h80, 1'b0, n);
        run8(OP_DIV,   8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, n);
        run8(OP_DIVU,  8'hC8, 8'h07, 8'h04, 8'h1C, 1'b0, n);
        run8(OP_DIV,   8'h80, 8'h03, 8'hFE, 8'hD6, 1'b0, n);
        run8(OP_DIV,   8'h05, 8'h00, 8'h05, 8'hFF, 1'b1, n);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("q32_drained", q32.size(), 32'd0);
        checkOutput("q8_drained", q8.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
